// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the SRAM-like port arbiter: owner tags and the request payload.
package sram_like_arbiter_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // wr + size + addr + wstrb + wdata
  localparam int SRAM_REQ_WD = 71;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order owner tag FIFO: one entry per accepted request, popped on each return.
module sram_like_arbiter_owner_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push,
  input  owner_e push_owner,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int PW = $clog2(DEPTH);

  owner_e        slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = slots[rd_ptr];

  // Tag storage; contents are don't-care while the slot is not counted.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_owner;
  end

  // Pointers wrap naturally at the power-of-2 depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between the inst and data masters: data priority,
// starvation guard for inst, lock while the slave stalls, and in-order return steering.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // inst master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared slave
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_stray
);

  owner_e    grant;
  owner_e    lock_owner;
  owner_e    head;
  logic      lock;
  logic [3:0] starve_cnt;
  logic      err_q;
  logic      fifo_full;
  logic      fifo_empty;
  logic      granted_req;
  logic      hs;
  logic      ret;
  sram_req_t inst_pkt;
  sram_req_t data_pkt;
  sram_req_t sel_pkt;

  assign inst_pkt = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
  assign data_pkt = {data_wr, data_size, data_addr, data_wstrb, data_wdata};

  // Grant select: a stalled request keeps the port, then starvation relief, then data first.
  always_comb begin
    grant = OWNER_INST;
    if (lock)
      grant = lock_owner;
    else if (starve_cnt == 4'(STARVE_LIMIT) && inst_req)
      grant = OWNER_INST;
    else if (data_req)
      grant = OWNER_DATA;
    else
      grant = OWNER_INST;
  end

  assign granted_req = (grant == OWNER_DATA) ? data_req : inst_req;
  // Full blocks issue even when a pop lands in the same cycle.
  assign mem_req     = resetn & granted_req & ~fifo_full;
  assign sel_pkt     = !resetn ? '0 : ((grant == OWNER_DATA) ? data_pkt : inst_pkt);
  assign {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} = sel_pkt;

  assign hs           = mem_req & mem_addr_ok;
  assign inst_addr_ok = hs & (grant == OWNER_INST);
  assign data_addr_ok = hs & (grant == OWNER_DATA);

  // Returns with nothing outstanding are dropped here and flagged by err_stray.
  assign ret          = resetn & mem_data_ok & ~fifo_empty;
  assign inst_data_ok = ret & (head == OWNER_INST);
  assign data_data_ok = ret & (head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_stray    = err_q & resetn;

  // Lock holds the grant from an unaccepted request until its handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock       <= 1'b0;
      lock_owner <= OWNER_INST;
    end else if (hs) begin
      lock <= 1'b0;
    end else if (mem_req) begin
      lock       <= 1'b1;
      lock_owner <= grant;
    end
  end

  // Counts data grants taken while inst waits; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!resetn)
      starve_cnt <= '0;
    else if (inst_addr_ok || !inst_req)
      starve_cnt <= '0;
    else if (data_addr_ok && starve_cnt != 4'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Sticky stray-return flag.
  always_ff @(posedge clk) begin
    if (!resetn)
      err_q <= 1'b0;
    else if (mem_data_ok && fifo_empty)
      err_q <= 1'b1;
  end

  sram_like_arbiter_owner_fifo #(.DEPTH(OUTST_DEPTH)) u_owner_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (hs),
    .push_owner(grant),
    .pop       (ret),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus a randomized
// run checked against a queue-based model of the arbitration rules.
module tb_sram_like_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [3:0]  inst_wstrb;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_stray;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTST_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_stray(err_stray)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = 4'hf; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = 4'hf; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    inst_addr = 32'h10; data_addr = 32'h20;
    tick(); #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0)
      $display("FAIL reset_oks: got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); else n_pass++;
    tick();
    idle_inputs(); resetn = 1; #1;
    n_checks++; if (err_stray !== 1'b0) $display("FAIL reset_err_stray: got %b want 0", err_stray); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_idle_req: got %b want 0", mem_req); else n_pass++;
    tick();
  endtask

  task automatic test_read_return();
    inst_req = 1; inst_addr = 32'hbfc00000; inst_wr = 0; mem_addr_ok = 1; #1;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hbfc00000)
      $display("FAIL rd_issue: got req=%b addr=%h want 1/bfc00000", mem_req, mem_addr); else n_pass++;
    n_checks++; if (inst_addr_ok !== 1'b1) $display("FAIL rd_addr_ok: got %b want 1", inst_addr_ok); else n_pass++;
    tick();
    inst_req = 0; mem_addr_ok = 0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin mem_data_ok = 1; mem_rdata = 32'h3c1d8000; end
      #1;
      n_checks++; if (inst_addr_ok !== 1'b0) $display("FAIL rd_addr_ok_pulse: got %b want 0 (cyc %0d)", inst_addr_ok, i); else n_pass++;
      n_checks++; if (inst_data_ok !== (i == 3) || data_data_ok !== 1'b0)
        $display("FAIL rd_data_ok: got inst=%b data=%b want %b/0 (cyc %0d)", inst_data_ok, data_data_ok, i == 3, i); else n_pass++;
      tick();
    end
    n_checks++; if (inst_rdata !== 32'h3c1d8000) $display("FAIL rd_rdata: got %h want 3c1d8000", inst_rdata); else n_pass++;
    mem_data_ok = 0; #1;
    n_checks++; if (inst_data_ok !== 1'b0) $display("FAIL rd_data_ok_end: got %b want 0", inst_data_ok); else n_pass++;
    tick();
  endtask

  task automatic test_data_priority();
    inst_req = 1; inst_addr = 32'h1000; data_req = 1; data_addr = 32'h2000; mem_addr_ok = 1; #1;
    n_checks++; if (mem_addr !== 32'h2000 || data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0)
      $display("FAIL prio_data_first: got addr=%h dok=%b iok=%b want 2000/1/0", mem_addr, data_addr_ok, inst_addr_ok); else n_pass++;
    tick();
    data_req = 0; #1;
    n_checks++; if (mem_addr !== 32'h1000 || inst_addr_ok !== 1'b1)
      $display("FAIL prio_inst_next: got addr=%h iok=%b want 1000/1", mem_addr, inst_addr_ok); else n_pass++;
    tick();
    inst_req = 0; mem_addr_ok = 0; tick();
    mem_data_ok = 1; mem_rdata = 32'h11; #1;
    n_checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0)
      $display("FAIL prio_ret1: got d=%b i=%b want 1/0", data_data_ok, inst_data_ok); else n_pass++;
    tick();
    mem_rdata = 32'h22; #1;
    n_checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0)
      $display("FAIL prio_ret2: got i=%b d=%b want 1/0", inst_data_ok, data_data_ok); else n_pass++;
    tick();
    mem_data_ok = 0; tick();
  endtask

  task automatic test_lock();
    inst_req = 1; inst_addr = 32'h3000; mem_addr_ok = 0;
    for (int c = 0; c < 5; c++) begin
      if (c >= 1) begin data_req = 1; data_addr = 32'h4000; end
      #1;
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0)
        $display("FAIL lock_hold: got req=%b addr=%h want 1/3000 (cyc %0d)", mem_req, mem_addr, c); else n_pass++;
      tick();
    end
    mem_addr_ok = 1; #1;
    n_checks++; if (mem_addr !== 32'h3000 || inst_addr_ok !== 1'b1)
      $display("FAIL lock_hs: got addr=%h iok=%b want 3000/1", mem_addr, inst_addr_ok); else n_pass++;
    tick();
    inst_req = 0; #1;
    n_checks++; if (mem_addr !== 32'h4000 || data_addr_ok !== 1'b1)
      $display("FAIL lock_after: got addr=%h dok=%b want 4000/1", mem_addr, data_addr_ok); else n_pass++;
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; #1;
    n_checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0)
      $display("FAIL lock_ret1: got i=%b d=%b want 1/0", inst_data_ok, data_data_ok); else n_pass++;
    tick(); #1;
    n_checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0)
      $display("FAIL lock_ret2: got d=%b i=%b want 1/0", data_data_ok, inst_data_ok); else n_pass++;
    tick();
    mem_data_ok = 0; tick();
  endtask

  task automatic test_full_fifo();
    mem_addr_ok = 1; data_req = 1;
    for (int i = 0; i < DEPTH; i++) begin
      data_addr = 32'h5000 + 32'(i * 4); #1;
      n_checks++; if (data_addr_ok !== 1'b1) $display("FAIL full_fill: got %b want 1 (req %0d)", data_addr_ok, i); else n_pass++;
      tick();
    end
    data_addr = 32'h5010; #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL full_block: got %b want 0", mem_req); else n_pass++;
    tick();
    mem_data_ok = 1; #1;
    n_checks++; if (mem_req !== 1'b0 || data_data_ok !== 1'b1)
      $display("FAIL full_pop_cycle: got req=%b dok=%b want 0/1", mem_req, data_data_ok); else n_pass++;
    tick();
    mem_data_ok = 0; #1;
    n_checks++; if (mem_req !== 1'b1 || data_addr_ok !== 1'b1 || mem_addr !== 32'h5010)
      $display("FAIL full_reassert: got req=%b ok=%b addr=%h want 1/1/5010", mem_req, data_addr_ok, mem_addr); else n_pass++;
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0)
        $display("FAIL full_drain: got d=%b i=%b want 1/0 (ret %0d)", data_data_ok, inst_data_ok, i); else n_pass++;
      tick();
    end
    mem_data_ok = 0; tick();
  endtask

  task automatic test_starvation();
    bit q[$];
    bit exp_g;
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < 15; k++) begin
      inst_addr = 32'h6000 + 32'(k); data_addr = 32'h7000 + 32'(k);
      mem_data_ok = (q.size() > 0); mem_rdata = $urandom;
      #1;
      exp_g = (k % (LIMIT + 1) == LIMIT);
      n_checks++; if ({inst_addr_ok, data_addr_ok} !== (exp_g ? 2'b10 : 2'b01))
        $display("FAIL starve_grant: got i=%b d=%b want inst=%b (grant %0d)", inst_addr_ok, data_addr_ok, exp_g, k); else n_pass++;
      if (mem_data_ok) begin
        n_checks++; if (inst_data_ok !== !q[0] || data_data_ok !== q[0] || inst_rdata !== mem_rdata)
          $display("FAIL starve_route: got i=%b d=%b want owner=%b (grant %0d)", inst_data_ok, data_data_ok, q[0], k); else n_pass++;
        void'(q.pop_front());
      end
      q.push_back(!exp_g);
      tick();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    while (q.size() > 0) begin
      mem_data_ok = 1; #1;
      n_checks++; if (data_data_ok !== q[0] || inst_data_ok !== !q[0])
        $display("FAIL starve_drain: got i=%b d=%b want owner=%b", inst_data_ok, data_data_ok, q[0]); else n_pass++;
      void'(q.pop_front());
      tick();
    end
    mem_data_ok = 0; tick();
  endtask

  task automatic test_stray_reset();
    idle_inputs(); mem_data_ok = 1; #1;
    n_checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0)
      $display("FAIL stray_no_ok: got i=%b d=%b want 0/0", inst_data_ok, data_data_ok); else n_pass++;
    tick();
    mem_data_ok = 0; #1;
    n_checks++; if (err_stray !== 1'b1) $display("FAIL stray_set: got %b want 1", err_stray); else n_pass++;
    tick(); #1;
    n_checks++; if (err_stray !== 1'b1) $display("FAIL stray_sticky: got %b want 1", err_stray); else n_pass++;
    data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 2; i++) begin
      data_addr = 32'h8000 + 32'(i); #1;
      n_checks++; if (data_addr_ok !== 1'b1) $display("FAIL stray_issue: got %b want 1", data_addr_ok); else n_pass++;
      tick();
    end
    data_req = 0; mem_addr_ok = 0; resetn = 0; #1;
    n_checks++; if (err_stray !== 1'b0) $display("FAIL stray_reset_low: got %b want 0", err_stray); else n_pass++;
    tick();
    resetn = 1; #1;
    n_checks++; if (err_stray !== 1'b0) $display("FAIL stray_cleared: got %b want 0", err_stray); else n_pass++;
    mem_data_ok = 1; #1;
    n_checks++; if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0)
      $display("FAIL stray_fifo_cleared: got d=%b i=%b want 0/0", data_data_ok, inst_data_ok); else n_pass++;
    tick();
    mem_data_ok = 0; resetn = 0; tick();
    resetn = 1; tick();
  endtask

  task automatic test_random(input int cycles);
    bit q[$];
    int starve = 0;
    bit locked = 0, lock_own = 0, inst_acc = 0, data_acc = 0;
    bit g, exp_req, hs, ret;
    logic [70:0] ipkt, dpkt, mpkt;
    idle_inputs();
    for (int c = 0; c < cycles; c++) begin
      if (inst_acc || !inst_req) begin
        inst_req = ($urandom_range(0, 2) != 0);
        inst_wr = 1'($urandom); inst_size = 2'($urandom_range(0, 2)); inst_addr = $urandom;
        inst_wstrb = 4'($urandom); inst_wdata = $urandom;
      end
      if (data_acc || !data_req) begin
        data_req = ($urandom_range(0, 2) != 0);
        data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2)); data_addr = $urandom;
        data_wstrb = 4'($urandom); data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      #1;
      if (locked) g = lock_own;
      else if (starve == LIMIT && inst_req) g = 0;
      else if (data_req) g = 1;
      else g = 0;
      exp_req = (g ? data_req : inst_req) && (q.size() < DEPTH);
      hs  = exp_req && mem_addr_ok;
      ret = mem_data_ok && (q.size() > 0);
      ipkt = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
      dpkt = {data_wr, data_size, data_addr, data_wstrb, data_wdata};
      mpkt = {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata};
      n_checks++; if (mem_req !== exp_req) $display("FAIL rnd_mem_req: got %b want %b (cyc %0d)", mem_req, exp_req, c); else n_pass++;
      if (exp_req) begin
        n_checks++; if (mpkt !== (g ? dpkt : ipkt))
          $display("FAIL rnd_payload: got %h want %h (cyc %0d)", mpkt, g ? dpkt : ipkt, c); else n_pass++;
      end
      n_checks++; if (inst_addr_ok !== (hs && !g) || data_addr_ok !== (hs && g))
        $display("FAIL rnd_addr_ok: got i=%b d=%b want %b/%b (cyc %0d)", inst_addr_ok, data_addr_ok, hs && !g, hs && g, c); else n_pass++;
      n_checks++; if (inst_data_ok !== (ret && !q[0]) || data_data_ok !== (ret && q[0]))
        $display("FAIL rnd_data_ok: got i=%b d=%b want %b/%b (cyc %0d)", inst_data_ok, data_data_ok, ret && !q[0], ret && q[0], c); else n_pass++;
      n_checks++; if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata || err_stray !== 1'b0)
        $display("FAIL rnd_rdata_err: got %h/%h err=%b want %h err=0 (cyc %0d)", inst_rdata, data_rdata, err_stray, mem_rdata, c); else n_pass++;
      inst_acc = hs && !g;
      data_acc = hs && g;
      if (hs) locked = 0;
      else if (exp_req) begin locked = 1; lock_own = g; end
      if (!inst_req || inst_acc) starve = 0;
      else if (data_acc && starve < LIMIT) starve++;
      if (ret) void'(q.pop_front());
      if (hs) q.push_back(g);
      tick();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
      mem_data_ok = 1; #1;
      n_checks++; if (data_data_ok !== q[0] || inst_data_ok !== !q[0])
        $display("FAIL rnd_drain: got i=%b d=%b want owner=%b", inst_data_ok, data_data_ok, q[0]); else n_pass++;
      void'(q.pop_front());
      tick();
    end
    mem_data_ok = 0;
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    test_reset();
    test_read_return();
    test_data_priority();
    test_lock();
    test_full_fifo();
    test_starvation();
    test_stray_reset();
    test_random(400);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
